// File: rtl/vdc_pkg.sv
// Shared helpers and types for the van der Corput sequence generator.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: clamp_k (period exponent clamp), rev_bits (variable-length bit
// reverse), vdc_word_t (32-bit container used by the helpers; callers slice
// it down to their own WIDTH).
package vdc_pkg;

   typedef logic [31:0] vdc_word_t;

   // Legal exponents are 1..width; 0 would be a degenerate one-element period.
   function automatic int unsigned clamp_k(input int unsigned req, input int unsigned width);
      int unsigned k;
      k = req;
      if (req == 0) begin
         k = 1;
      end else if (req > width) begin
         k = width;
      end
      return k;
   endfunction

   // Reverse the low k bits of value: mirror all 32 bits, then shift the
   // mirrored field back down so it occupies bits [k-1:0].
   function automatic vdc_word_t rev_bits(input vdc_word_t value, input int unsigned k);
      vdc_word_t r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = value[31-i];
      end
      return r >> (32 - k);
   endfunction

endpackage

// File: rtl/vdc_lane.sv
// One output channel: phase-offset add, k-bit reverse, left-align, optional scramble.
// Latency: combinational, zero cycles from count_i/k_i.
// Backpressure: none; follows the shared counter.
// Ports: count_i shared counter, k_i period exponent, key_i scramble key
// (only when VDC_SCRAMBLE_EN is defined), seq_o aligned VDC value.
module vdc_lane
   import vdc_pkg::*;
#(
   parameter int          WIDTH  = 8,
   parameter int          KW     = 4,
   parameter int unsigned OFFSET = 0
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic [KW-1:0]    k_i,
`ifdef VDC_SCRAMBLE_EN
   input  logic [WIDTH-1:0] key_i,
`endif
   output logic [WIDTH-1:0] seq_o
);

   // Offset truncated to WIDTH+1 bits; harmless since the result is reduced mod 2^k, k <= WIDTH.
   localparam logic [WIDTH:0] OFS = (WIDTH+1)'(OFFSET);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   k_mask;
   logic [WIDTH:0]   m;
   vdc_word_t        rev;
   logic [WIDTH-1:0] aligned;
   logic [WIDTH-1:0] top_mask;

   always_comb begin
      sum      = {1'b0, count_i} + OFS;
      k_mask   = ((WIDTH+1)'(1) << k_i) - (WIDTH+1)'(1);
      m        = sum & k_mask;
      rev      = rev_bits(32'(m), 32'(k_i));
      aligned  = WIDTH'(rev << (32'(WIDTH) - 32'(k_i)));
      // Ones over the top k bits; the bits below the aligned field stay clear.
      top_mask = ~WIDTH'((32'd1 << (32'(WIDTH) - 32'(k_i))) - 32'd1);
`ifdef VDC_SCRAMBLE_EN
      seq_o    = aligned ^ (key_i & top_mask);
`else
      seq_o    = aligned & top_mask;
`endif
   end

endmodule

// File: rtl/vdc_seq_gen.sv
// Multi-channel base-2 van der Corput generator with run-time period 2^k.
// Latency: outputs combinational from the count register (zero cycles).
// Backpressure: enable=0 stalls the counter; outputs hold.
// Ports: clock, reset (async active-high), start (restart + latch period_log2),
// enable (advance), period_log2 (requested k), seq_out (CHANNELS x WIDTH VDC),
// seq_raw (natural-order count), valid, period_done.
// Build option VDC_SCRAMBLE_EN adds key_load/key_sel/key_in and per-channel
// XOR keys masked to the top k bits.
module vdc_seq_gen
   import vdc_pkg::*;
#(
   parameter int  WIDTH    = 8,
   parameter int  CHANNELS = 4,
   parameter int  PHASE    = 1,
   localparam int KW       = $clog2(WIDTH + 1),
   localparam int KSW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      enable,
   input  logic [KW-1:0]             period_log2,
`ifdef VDC_SCRAMBLE_EN
   input  logic                      key_load,
   input  logic [KSW-1:0]            key_sel,
   input  logic [WIDTH-1:0]          key_in,
`endif
   output logic [CHANNELS*WIDTH-1:0] seq_out,
   output logic [WIDTH-1:0]          seq_raw,
   output logic                      valid,
   output logic                      period_done
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [KW-1:0]    k_q, k_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] k_mask;
   logic             last_elem;
   logic [WIDTH-1:0] lane_seq [CHANNELS];

   assign k_mask    = WIDTH'((32'd1 << k_q) - 32'd1);
   assign last_elem = (count_q == k_mask);

   always_comb begin
      count_d = count_q;
      k_d     = k_q;
      valid_d = valid_q;
      // start wins over enable so a restart always lands on element 0.
      if (start) begin
         count_d = '0;
         k_d     = KW'(clamp_k(32'(period_log2), WIDTH));
         valid_d = 1'b1;
      end else if (enable && valid_q) begin
         count_d = (count_q + WIDTH'(1)) & k_mask;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         k_q     <= KW'(WIDTH);
         valid_q <= 1'b0;
      end else begin
         count_q <= count_d;
         k_q     <= k_d;
         valid_q <= valid_d;
      end
   end

`ifdef VDC_SCRAMBLE_EN
   logic [WIDTH-1:0] key_q [CHANNELS];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            key_q[c] <= '0;
         end
      end else if (key_load && (32'(key_sel) < CHANNELS)) begin
         key_q[key_sel] <= key_in;
      end
   end
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      vdc_lane #(
         .WIDTH  (WIDTH),
         .KW     (KW),
         .OFFSET (32'(c * PHASE))
      ) u_lane (
         .count_i (count_q),
         .k_i     (k_q),
`ifdef VDC_SCRAMBLE_EN
         .key_i   (key_q[c]),
`endif
         .seq_o   (lane_seq[c])
      );
      // Lanes with a nonzero offset produce nonzero values at count 0, so gate on valid.
      assign seq_out[c*WIDTH +: WIDTH] = valid_q ? lane_seq[c] : '0;
   end

   assign seq_raw     = valid_q ? count_q : '0;
   assign valid       = valid_q;
   assign period_done = valid_q & enable & ~start & last_elem;

endmodule

// File: tb/tb_vdc_seq_gen.sv
// Self-checking bench for vdc_seq_gen (WIDTH=4, CHANNELS=2, PHASE=1).
// Latency: outputs sampled 1 ns after inputs change, before the active edge.
// Backpressure: random enable stalls exercised against the reference model.
module tb_vdc_seq_gen;

   localparam int W  = 4;
   localparam int CH = 2;
   localparam int PH = 1;
   localparam int KW = $clog2(W + 1);

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            enable = 1'b0;
   logic [KW-1:0]   period_log2 = '0;
   logic [CH*W-1:0] seq_out;
   logic [W-1:0]    seq_raw;
   logic            valid;
   logic            period_done;

`ifdef VDC_SCRAMBLE_EN
   logic            key_load = 1'b0;
   logic [0:0]      key_sel = '0;
   logic [W-1:0]    key_in = '0;
   logic            nxt_kl = 1'b0;
   logic [0:0]      nxt_ks = '0;
   logic [W-1:0]    nxt_kv = '0;
   int              m_key [CH];
`endif

   vdc_seq_gen #(.WIDTH(W), .CHANNELS(CH), .PHASE(PH)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .enable      (enable),
      .period_log2 (period_log2),
`ifdef VDC_SCRAMBLE_EN
      .key_load    (key_load),
      .key_sel     (key_sel),
      .key_in      (key_in),
`endif
      .seq_out     (seq_out),
      .seq_raw     (seq_raw),
      .valid       (valid),
      .period_done (period_done)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state: value after the most recent edge.
   int m_cnt, m_k, m_valid;
   int obs_ch [CH];
   int obs_raw, obs_pd, obs_valid;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected channel value straight from the definition: offset index,
   // reverse k digits arithmetically, shift to the top of the word.
   function automatic int exp_seq(input int c);
      int m, r;
      if (m_valid == 0) return 0;
      m = (m_cnt + c * PH) % (1 << m_k);
      r = 0;
      for (int j = 0; j < m_k; j++) begin
         r = (r << 1) | ((m >> j) & 1);
      end
      r = r << (W - m_k);
`ifdef VDC_SCRAMBLE_EN
      r = r ^ ((m_key[c] >> (W - m_k)) << (W - m_k));
`endif
      return r;
   endfunction

   task automatic check_outputs(input string tag, input bit st, input bit en);
      int exp_pd;
      for (int c = 0; c < CH; c++) begin
         obs_ch[c] = int'(seq_out[c*W +: W]);
         check($sformatf("%s_ch%0d", tag, c), obs_ch[c], exp_seq(c));
      end
      obs_raw   = int'(seq_raw);
      obs_pd    = int'(period_done);
      obs_valid = int'(valid);
      exp_pd = (m_valid != 0 && en && !st && m_cnt == (1 << m_k) - 1) ? 1 : 0;
      check({tag, "_raw"}, obs_raw, (m_valid != 0) ? m_cnt : 0);
      check({tag, "_valid"}, obs_valid, m_valid);
      check({tag, "_pd"}, obs_pd, exp_pd);
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_k     = W;
      m_valid = 0;
`ifdef VDC_SCRAMBLE_EN
      for (int c = 0; c < CH; c++) m_key[c] = 0;
`endif
   endtask

   // One clock: drive at negedge, check pre-edge outputs, advance model, cross posedge.
   task automatic step(input bit st, input int pk, input bit en);
      @(negedge clock);
      start       = st;
      period_log2 = KW'(pk);
      enable      = en;
`ifdef VDC_SCRAMBLE_EN
      key_load = nxt_kl;
      key_sel  = nxt_ks;
      key_in   = nxt_kv;
`endif
      #1;
      check_outputs("step", st, en);
      if (st) begin
         m_cnt   = 0;
         m_k     = (pk == 0) ? 1 : ((pk > W) ? W : pk);
         m_valid = 1;
      end else if (en && m_valid != 0) begin
         m_cnt = (m_cnt + 1) % (1 << m_k);
      end
`ifdef VDC_SCRAMBLE_EN
      if (nxt_kl && int'(nxt_ks) < CH) m_key[nxt_ks] = int'(nxt_kv);
      nxt_kl = 1'b0;
`endif
      @(posedge clock);
      #1;
   endtask

   // Reset pulse placed between edges so only the asynchronous path can clear state.
   task automatic async_reset();
      @(negedge clock);
      start = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_outputs("arst", 1'b0, enable);
      #1;
      reset = 1'b0;
   endtask

   int t_ch0 [4];
   int t_ch1 [4];

   initial begin
      model_reset();
      #3;
      check_outputs("reset", 1'b0, 1'b0);
      #5;
      reset = 1'b0;

      // Enable before any start must be ignored.
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      check("pre_start_raw", obs_raw, 0);

`ifdef VDC_SCRAMBLE_EN
      nxt_kl = 1'b1; nxt_ks = 1'b0; nxt_kv = 4'b1010;
      step(1'b0, 0, 1'b0);
      t_ch0 = '{10, 2, 14, 6};
`else
      t_ch0 = '{0, 8, 4, 12};
`endif
      t_ch1 = '{8, 4, 12, 2};

      // k=4 first four elements.
      step(1'b1, 4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4, 1'b1);
         check($sformatf("k4_ch0_%0d", i), obs_ch[0], t_ch0[i]);
         check($sformatf("k4_ch1_%0d", i), obs_ch[1], t_ch1[i]);
         check($sformatf("k4_raw_%0d", i), obs_raw, i);
      end

      // k=2, two full periods.
`ifdef VDC_SCRAMBLE_EN
      t_ch0 = '{8, 0, 12, 4};
`else
      t_ch0 = '{0, 8, 4, 12};
`endif
      step(1'b1, 2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 2, 1'b1);
         check($sformatf("k2_ch0_%0d", i), obs_ch[0], t_ch0[i % 4]);
         check($sformatf("k2_pd_%0d", i), obs_pd, (i % 4 == 3) ? 1 : 0);
      end

      // period_log2=0 clamps to k=1.
      step(1'b1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 0, 1'b1);
`ifdef VDC_SCRAMBLE_EN
         check($sformatf("k1_ch0_%0d", i), obs_ch[0], (i % 2 == 0) ? 8 : 0);
`else
         check($sformatf("k1_ch0_%0d", i), obs_ch[0], (i % 2 == 0) ? 0 : 8);
`endif
      end

      // Stall at the last element: period_done only in the enabled cycle.
      step(1'b1, 2, 1'b0);
      step(1'b0, 2, 1'b1);
      step(1'b0, 2, 1'b1);
      step(1'b0, 2, 1'b1);
      check("stall_pd_a", obs_pd, 0);
      step(1'b0, 2, 1'b0);
      check("stall_pd_b", obs_pd, 0);
      step(1'b0, 2, 1'b0);
      check("stall_raw", obs_raw, 3);
      step(1'b0, 2, 1'b1);
      check("stall_pd_c", obs_pd, 1);
      step(1'b0, 2, 1'b0);
      check("stall_wrap", obs_raw, 0);

      // start with enable at count 2, period_log2 over range -> k=4.
      step(1'b0, 2, 1'b1);
      step(1'b0, 2, 1'b1);
      step(1'b1, 7, 1'b1);
      check("se_raw_before", obs_raw, 2);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 0, 1'b1);
         check($sformatf("se_raw_%0d", i), obs_raw, i);
      end

      // Asynchronous reset at count 5; enable ignored afterwards until start.
      async_reset();
      check("arst_valid", obs_valid, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3, 1'b1);
         check($sformatf("post_arst_raw_%0d", i), obs_raw, 0);
      end

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         bit st, en;
         int pk;
         if ($urandom_range(0, 99) < 2) begin
            async_reset();
         end else begin
            st = ($urandom_range(0, 7) == 0);
            pk = int'($urandom_range(0, 7));
            en = ($urandom_range(0, 3) != 0);
`ifdef VDC_SCRAMBLE_EN
            if ($urandom_range(0, 7) == 0) begin
               nxt_kl = 1'b1;
               nxt_ks = 1'($urandom_range(0, 1));
               nxt_kv = W'($urandom_range(0, 15));
            end
`endif
            step(st, pk, en);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
